// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared constants for the memory port arbiter: state encoding
//               and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_STARVE_LIM  = 4;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester (fetch / data stage) and shared memory port signals.
//               master = arbiter side, slave = pipeline + memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    // data-stage requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    // shared memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that saturates at LIMIT and
//               flags when it sits at the limit. Clear has priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_cnt,
    output logic                  o_at_lim
);

    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // next count: clear wins, otherwise step up until the limit
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt    = cnt_q;
    assign o_at_lim = (cnt_q == C_LIMIT);

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one external memory port between the fetch and
//               data stages. Data has priority unless a fetch has been
//               passed over STARVE_LIM times; a stuck access times out.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int STARVE_LIM  = DEF_STARVE_LIM,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.master bus,
    output logic               stall_f,
    output logic               stall_m,
    output logic               busy,
    output logic               timeout_err
);

    localparam int STARVE_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam int TMO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    arb_state_e          state_d, state_q;
    logic                mem_req_d, mem_req_q;
    logic                mem_we_d, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_d, if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_d, dm_rdata_q;
    logic                if_valid_d, if_valid_q;
    logic                dm_valid_d, dm_valid_q;
    logic                timeout_err_d, timeout_err_q;

    logic                w_grant_data;
    logic                w_grant_fetch;
    logic                w_if_ok;
    logic                w_dm_ok;
    logic [STARVE_W-1:0] w_starve_cnt;
    logic                w_starve_at_lim;
    logic [TMO_W-1:0]    w_tmo_cnt;
    logic                w_tmo_at_lim;
    logic                w_busy_state;

    // a requester whose completion pulse is showing is not asking again
    assign w_if_ok      = bus.if_req & ~if_valid_q;
    assign w_dm_ok      = bus.dm_req & ~dm_valid_q;
    assign w_busy_state = (state_q != ST_IDLE);

    // runs of data grants while a fetch waits
    sat_counter #(.WIDTH(STARVE_W), .LIMIT(STARVE_LIM)) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_grant_fetch | (w_grant_data & ~bus.if_req)),
        .i_inc    (w_grant_data & bus.if_req),
        .o_cnt    (w_starve_cnt),
        .o_at_lim (w_starve_at_lim)
    );

    // cycles spent waiting on memory; at the limit the current cycle is the
    // TIMEOUT_CYC-th one, so the limit is TIMEOUT_CYC-1
    sat_counter #(.WIDTH(TMO_W), .LIMIT(TIMEOUT_CYC - 1)) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (~w_busy_state),
        .i_inc    (w_busy_state),
        .o_cnt    (w_tmo_cnt),
        .o_at_lim (w_tmo_at_lim)
    );

    // arbitration, memory port hold and completion handling
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        if_valid_d    = 1'b0;
        dm_valid_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_dm_ok && !(w_if_ok && w_starve_at_lim)) begin
                    w_grant_data = 1'b1;
                    state_d      = ST_DATA;
                    mem_req_d    = 1'b1;
                    mem_we_d     = bus.dm_we;
                    mem_addr_d   = bus.dm_addr;
                    mem_wdata_d  = bus.dm_wdata;
                end else if (w_if_ok && (!bus.dm_req || w_starve_at_lim)) begin
                    w_grant_fetch = 1'b1;
                    state_d       = ST_FETCH;
                    mem_req_d     = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = bus.if_addr;
                    mem_wdata_d   = '0;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (bus.mem_ready || w_tmo_at_lim) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!bus.mem_ready) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == ST_FETCH) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!bus.mem_ready) begin
                            dm_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            if_valid_q    <= 1'b0;
            dm_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
            if_valid_q    <= if_valid_d;
            dm_valid_q    <= dm_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;

    assign stall_f     = bus.if_req & ~if_valid_q;
    assign stall_m     = bus.dm_req & ~dm_valid_q;
    assign busy        = w_busy_state & ~rst;
    assign timeout_err = timeout_err_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               latency-programmable memory responder and a grant logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic stall_f, stall_m, busy, timeout_err;

    int          n_checks = 0;
    int          n_errors = 0;

    int          mem_lat  = 0;
    bit          mem_hang = 0;
    logic [31:0] rsp_data = '0;
    int          wait_cnt = 0;

    bit          log_en   = 0;
    logic        prev_req = 1'b0;
    logic [31:0] g_addr[$];
    logic [31:0] g_starve[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIM  (4),
        .TIMEOUT_CYC (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .stall_f     (stall_f),
        .stall_m     (stall_m),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // memory model: raises mem_ready mem_lat cycles after mem_req rises
    always @(negedge clk) begin
        if (bus.mem_req && !mem_hang) begin
            if (wait_cnt >= mem_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rsp_data;
                wait_cnt      = 0;
            end else begin
                bus.mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ready = 1'b0;
            wait_cnt      = 0;
        end
    end

    // grant logger: address and starvation count at each new mem_req
    always @(negedge clk) begin
        if (log_en && bus.mem_req && !prev_req) begin
            g_addr.push_back(bus.mem_addr);
            g_starve.push_back(32'(u_dut.w_starve_cnt));
        end
        prev_req = bus.mem_req;
    end

    initial begin
        logic [31:0] exp_addr[5];
        logic [31:0] exp_stv[5];
        int          hi;
        bit          seen;

        rst          = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_tmo_err", 32'(timeout_err), 32'd0);
        chk_eq("rst_if_rdata", bus.if_rdata, 32'd0);
        chk_eq("rst_dm_rdata", bus.dm_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // fetch only, memory answers one cycle after mem_req
        mem_lat     = 1;
        rsp_data    = 32'h0050_0093;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        chk_eq("f_mem_req", 32'(bus.mem_req), 32'd1);
        chk_eq("f_mem_addr", bus.mem_addr, 32'h10);
        chk_eq("f_mem_we", 32'(bus.mem_we), 32'd0);
        chk_eq("f_stall_f", 32'(stall_f), 32'd1);
        chk_eq("f_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk_eq("f_valid_early", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        chk_eq("f_valid", 32'(bus.if_valid), 32'd1);
        chk_eq("f_rdata", bus.if_rdata, 32'h0050_0093);
        chk_eq("f_stall_f_done", 32'(stall_f), 32'd0);
        chk_eq("f_mem_req_drop", 32'(bus.mem_req), 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk_eq("f_valid_pulse", 32'(bus.if_valid), 32'd0);
        chk_eq("f_rdata_hold", bus.if_rdata, 32'h0050_0093);

        // simultaneous fetch + load: data first, then fetch
        mem_lat     = 0;
        rsp_data    = 32'h1111_2222;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h14;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h40;
        @(negedge clk);
        chk_eq("s_mem_addr_data", bus.mem_addr, 32'h40);
        chk_eq("s_stall_f", 32'(stall_f), 32'd1);
        chk_eq("s_stall_m", 32'(stall_m), 32'd1);
        chk_eq("s_starve_1", 32'(u_dut.w_starve_cnt), 32'd1);
        @(negedge clk);
        chk_eq("s_dm_valid", 32'(bus.dm_valid), 32'd1);
        chk_eq("s_dm_rdata", bus.dm_rdata, 32'h1111_2222);
        chk_eq("s_stall_f_hold", 32'(stall_f), 32'd1);
        bus.dm_req = 1'b0;
        rsp_data   = 32'h3333_4444;
        @(negedge clk);
        chk_eq("s_mem_addr_fetch", bus.mem_addr, 32'h14);
        chk_eq("s_starve_0", 32'(u_dut.w_starve_cnt), 32'd0);
        @(negedge clk);
        chk_eq("s_if_valid", 32'(bus.if_valid), 32'd1);
        chk_eq("s_if_rdata", bus.if_rdata, 32'h3333_4444);
        chk_eq("s_dm_rdata_hold", bus.dm_rdata, 32'h1111_2222);
        bus.if_req = 1'b0;
        @(negedge clk);

        // store: dm_rdata must not change
        rsp_data     = 32'h5555_5555;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h80;
        bus.dm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_eq("w_mem_we", 32'(bus.mem_we), 32'd1);
        chk_eq("w_mem_addr", bus.mem_addr, 32'h80);
        chk_eq("w_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk_eq("w_dm_valid", 32'(bus.dm_valid), 32'd1);
        chk_eq("w_dm_rdata", bus.dm_rdata, 32'h1111_2222);
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        @(negedge clk);

        // starvation: 4 data grants then one fetch
        g_addr.delete();
        g_starve.delete();
        log_en      = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h40;
        seen        = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.if_valid) seen = 1'b1;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        chk_eq("sv_fetch_done", 32'(seen), 32'd1);
        @(negedge clk);
        log_en = 1'b0;
        exp_addr = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h10};
        exp_stv  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        chk_eq("sv_grant_count", 32'(g_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_addr.size()) begin
                chk_eq($sformatf("sv_grant_addr_%0d", i), g_addr[i], exp_addr[i]);
                chk_eq($sformatf("sv_starve_%0d", i), g_starve[i], exp_stv[i]);
            end
        end
        @(negedge clk);

        // timeout on a fetch: 8 cycles of mem_req, then valid with zero data
        mem_hang    = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_req) hi++;
            @(negedge clk);
        end
        chk_eq("t_req_cycles", 32'(hi), 32'd8);
        chk_eq("t_mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk_eq("t_if_valid", 32'(bus.if_valid), 32'd1);
        chk_eq("t_if_rdata", bus.if_rdata, 32'd0);
        chk_eq("t_err", 32'(timeout_err), 32'd1);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk_eq("t_err_sticky", 32'(timeout_err), 32'd1);
        chk_eq("t_valid_pulse", 32'(bus.if_valid), 32'd0);

        // reset during a data access
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h44;
        @(negedge clk);
        chk_eq("r_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("r_mem_req", 32'(bus.mem_req), 32'd0);
        chk_eq("r_dm_valid", 32'(bus.dm_valid), 32'd0);
        chk_eq("r_err_clr", 32'(timeout_err), 32'd0);
        rst        = 1'b0;
        bus.dm_req = 1'b0;
        mem_hang   = 1'b0;
        @(negedge clk);
        chk_eq("r_idle", 32'(busy), 32'd0);
        chk_eq("r_no_valid", 32'(bus.dm_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, maximum consecutive data grants while a fetch is pending.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, maximum cycles waiting for mem_ready.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port if_req  in  1  fetch read request; level, held until if_valid.
REQ-008 SHALL have port if_addr  in  ADDR_W  fetch address; stable while if_req is high.
REQ-009 SHALL have ports if_rdata  out  DATA_W and if_valid  out  1  carrying fetch data and a one-cycle completion pulse.
REQ-010 SHALL have ports dm_req  in  1, dm_we  in  1, dm_addr  in  ADDR_W, dm_wdata  in  DATA_W  forming the data-stage request, all stable while dm_req is high.
REQ-011 SHALL have ports dm_rdata  out  DATA_W and dm_valid  out  1  carrying load data and a one-cycle completion pulse.
REQ-012 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  driving the shared memory port, all registered.
REQ-013 SHALL have ports mem_ready  in  1 and mem_rdata  in  DATA_W  from memory; mem_rdata is valid in the cycle mem_ready is high.
REQ-014 SHALL have ports stall_f  out  1 and stall_m  out  1  stall requests to the fetch and memory stages.
REQ-015 SHALL have ports busy  out  1 (state not IDLE) and timeout_err  out  1 (sticky error).

Function
REQ-016 SHALL implement a finite-state machine (FSM) with states IDLE, FETCH and DATA.
REQ-017 In IDLE, SHALL grant DATA when dm_req is high, except when if_req is also high and starve_cnt equals STARVE_LIM, in which case it SHALL grant FETCH.
REQ-018 In IDLE, SHALL grant FETCH when only if_req is high.
REQ-019 In IDLE, SHALL ignore any requester whose valid output is high in the same cycle, so that a completed request is not granted again.
REQ-020 On a grant edge, SHALL register the address, write enable (0 for fetch) and write data onto mem_*, and SHALL set mem_req to 1 from the next cycle.
REQ-021 SHALL hold mem_req and all mem_* outputs constant until mem_ready is sampled high.
REQ-022 On the edge where mem_ready is sampled high, SHALL drop mem_req, return to IDLE, register mem_rdata into the granted requester's rdata, and pulse that requester's valid for exactly one cycle.
REQ-023 Timing: a request sampled at edge k, with mem_ready first high L cycles after mem_req rises, SHALL assert mem_req from cycle k+1 and valid in cycle k+2+L; the minimum is 2 cycles.
REQ-024 For writes (dm_we=1), SHALL pulse dm_valid and leave dm_rdata unchanged.
REQ-025 SHALL leave if_rdata and dm_rdata holding their last value between valid pulses.
REQ-026 SHALL increment starve_cnt on each data grant made while if_req is high, and SHALL clear it on a fetch grant or on a data grant made while if_req is low.
REQ-027 SHALL saturate starve_cnt at STARVE_LIM.
REQ-028 SHALL derive stall_f = if_req & ~if_valid and stall_m = dm_req & ~dm_valid combinationally.
REQ-029 SHALL count cycles in FETCH and DATA; when the count reaches TIMEOUT_CYC without mem_ready, SHALL drop mem_req, return to IDLE, pulse the granted requester's valid with rdata set to 0, and set timeout_err.
REQ-030 SHALL keep timeout_err set until reset.
REQ-031 SHALL ignore mem_ready while in IDLE.

Reset
REQ-032 When rst is high at a clock edge, SHALL enter IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid, starve_cnt, the timeout counter and timeout_err.
REQ-033 When rst is high at a clock edge during a transaction, SHALL abort that transaction with no valid pulse.
REQ-034 SHALL drive busy to 0 while in reset.

Structure
REQ-035 The FSM state encoding (IDLE=2'd0, FETCH=2'd1, DATA=2'd2) and the default parameter values SHALL reside in the shared pipeline constants package or header.
REQ-036 The starvation and timeout counters SHALL each be an instance of one sub-module, sat_counter, providing clear, increment, a saturation limit and an at-limit flag.
REQ-037 SHALL contain no memory array; the memory remains external.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x10, mem_ready high 1 cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_valid a single pulse 3 cycles after the request edge, if_rdata=0x00500093, stall_f low after the pulse.
REQ-039 Simultaneous requests: if_req and dm_req (load, addr 0x40) rise together -> DATA granted first, fetch granted on the next IDLE, stall_f high throughout the data access.
REQ-040 Starvation: dm_req held high continuously with if_req high and STARVE_LIM=4 -> exactly 4 data grants, then 1 fetch grant, then starve_cnt=0.
REQ-041 Store: dm_we=1, dm_addr=0x80, dm_wdata=0xDEADBEEF -> mem_we=1 with that address and data, dm_valid pulses, dm_rdata unchanged.
REQ-042 Timeout: mem_ready held low with TIMEOUT_CYC=8 -> mem_req drops after 8 cycles, valid pulses with rdata=0, timeout_err=1 until rst.
REQ-043 Reset mid-access: rst asserted during DATA -> next cycle IDLE, mem_req=0, no dm_valid pulse.
